// File: rtl/scpu_pkg.sv
// Shared CPU definitions: next-PC operation encoding and PC-unit defaults.
// Codes 000-011 keep the meaning of the legacy 2-bit NPC selector.
package scpu_pkg;

  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_RS     = 3'b011,
    NPC_JAL    = 3'b100,
    NPC_RET    = 3'b101,
    NPC_EXC    = 3'b110,
    NPC_ERET   = 3'b111
  } npc_op_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

  // True for ops whose target comes from a register and so may be misaligned.
  function automatic logic op_may_misalign(npc_op_e op);
    return (op == NPC_RS) || (op == NPC_RET) || (op == NPC_ERET);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the pipeline control logic and pc_unit.
// master = control unit / register file side, slave = pc_unit.
interface pc_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  import scpu_pkg::*;

  logic             stall;
  npc_op_e          npc_op;
  logic [25:0]      imm;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] npc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] epc;
  logic             addr_err;
  logic             ras_empty;
  logic             ras_full;
  logic [CNT_W-1:0] ras_hit_cnt;
  logic [CNT_W-1:0] ras_miss_cnt;

  modport master (
    output stall, npc_op, imm, rs,
    input  pc, npc, pc_plus4, epc, addr_err,
    input  ras_empty, ras_full, ras_hit_cnt, ras_miss_cnt
  );

  modport slave (
    input  stall, npc_op, imm, rs,
    output pc, npc, pc_plus4, epc, addr_err,
    output ras_empty, ras_full, ras_hit_cnt, ras_miss_cnt
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// One-cycle update; push takes priority if both are requested.
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_dat,
  output logic [WIDTH-1:0] top_dat,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] top_idx;

  // ptr_q is the next free slot, which is also the oldest slot once full.
  assign top_idx = ptr_q - PTR_W'(1);
  assign top_dat = mem_q[top_idx];
  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OCC_MAX);

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    occ_d = occ_q;
    if (push) begin
      mem_d[ptr_q] = push_dat;
      ptr_d        = ptr_q + PTR_W'(1);
      occ_d        = full ? occ_q : occ_q + OCC_W'(1);
    end else if (pop && !empty) begin
      ptr_d = top_idx;
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC selection, EPC, return-address stack and RET statistics.
// npc is combinational; pc updates on the next edge unless stalled (EXC ignores stall).
module pc_unit
  import scpu_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int          RAS_DEPTH  = 4,
  parameter int          CNT_W      = 16
) (
  input  logic    clk,
  input  logic    rst,
  pc_unit_if.slave bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] raw_tgt;
  logic [WIDTH-1:0] npc;
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;

  assign pc4    = pc_q + WIDTH'(4);
  assign br_off = {{(WIDTH-18){bus.imm[15]}}, bus.imm[15:0], 2'b00};

  always_comb begin
    raw_tgt = pc4;
    case (bus.npc_op)
      NPC_PLUS4:         raw_tgt = pc4;
      NPC_BRANCH:        raw_tgt = pc4 + br_off;
      NPC_JUMP, NPC_JAL: raw_tgt = {pc4[WIDTH-1:28], bus.imm, 2'b00};
      NPC_RS, NPC_RET:   raw_tgt = bus.rs;
      NPC_EXC:           raw_tgt = WIDTH'(EXC_VECTOR);
      NPC_ERET:          raw_tgt = epc_q;
      default:           raw_tgt = pc4;
    endcase
  end

  assign npc = {raw_tgt[WIDTH-1:2], 2'b00};

  // The RAS only gathers statistics; the RET target is always rs.
  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (bus.npc_op == NPC_EXC) begin
      pc_d  = npc;
      epc_d = pc_q;
    end else if (!bus.stall) begin
      pc_d = npc;
      if (bus.npc_op == NPC_JAL) begin
        ras_push = 1'b1;
      end else if (bus.npc_op == NPC_RET) begin
        if (ras_empty) begin
          miss_d = (miss_q == '1) ? miss_q : miss_q + CNT_W'(1);
        end else begin
          ras_pop = 1'b1;
          if (ras_top == bus.rs) hit_d  = (hit_q == '1) ? hit_q : hit_q + CNT_W'(1);
          else                   miss_d = (miss_q == '1) ? miss_q : miss_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= WIDTH'(RESET_PC);
      epc_q  <= '0;
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_dat (pc4),
    .top_dat  (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  assign bus.pc           = pc_q;
  assign bus.npc          = npc;
  assign bus.pc_plus4     = pc4;
  assign bus.epc          = epc_q;
  assign bus.addr_err     = op_may_misalign(bus.npc_op) && (raw_tgt[1:0] != 2'b00);
  assign bus.ras_empty    = ras_empty;
  assign bus.ras_full     = ras_full;
  assign bus.ras_hit_cnt  = hit_q;
  assign bus.ras_miss_cnt = miss_q;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle and pipelined MIPS cores. It holds the PC register and computes the next PC for sequential, branch, jump, register-indirect, exception and exception-return flow. It keeps a small return-address stack (RAS) with hit statistics and an EPC register. It replaces the purely combinational next-PC selector and sits between the control unit / register file and the instruction memory address port.

## Interface
- `WIDTH`, 32: PC/data width; must be ≥ 32.
- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `EXC_VECTOR`, 32'h0000_4180: exception handler entry address.
- `RAS_DEPTH`, 4: return-address stack entries; power of two, ≥ 2.
- `CNT_W`, 16: width of RAS hit/miss counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  hold PC and all state (overridden by EXC).
- `npc_op`  in  3  000 PLUS4, 001 BRANCH, 010 JUMP, 011 RS, 100 JAL, 101 RET, 110 EXC, 111 ERET.
- `imm`  in  26  instruction index / branch offset in [15:0].
- `rs`  in  WIDTH  register operand for RS/RET.
- `pc`  out  WIDTH  current PC (registered).
- `npc`  out  WIDTH  next PC (combinational).
- `pc_plus4`  out  WIDTH  pc+4, for link write-back.
- `epc`  out  WIDTH  saved exception PC.
- `addr_err`  out  1  computed target misaligned (comb.).
- `ras_empty`, `ras_full`  out  1  RAS status.
- `ras_hit_cnt`, `ras_miss_cnt`  out  CNT_W  saturating RET statistics.

## Operation
- pc4 = pc+4, modulo 2^WIDTH; 0xFFFF_FFFC wraps to 0.
- Next-PC selection:
  - PLUS4: pc4.
  - BRANCH: pc4 + sign-extended {imm[15:0],2'b00}.
  - JUMP/JAL: {pc4[WIDTH-1:28], imm, 2'b00}.
  - RS/RET: rs.
  - EXC: EXC_VECTOR.
  - ERET: epc.
- Alignment:
  - If the raw target has [1:0] ≠ 0, addr_err=1 and npc uses the target with [1:0] forced to 00.
  - Only RS/RET/ERET can misalign.
- JAL pushes pc4 onto the RAS.
  - Full stack: overwrite the oldest entry (circular); ras_full stays 1; depth count saturates at RAS_DEPTH.
- RET pops the RAS.
  - Non-empty: compare top with rs. Equal increments ras_hit_cnt, otherwise ras_miss_cnt (each saturating at all-ones). Then pop.
  - Empty: no pop, ras_miss_cnt increments.
  - The target is always rs; the RAS never alters control flow.
- EXC: epc ← pc (the faulting instruction), pc ← EXC_VECTOR. The RAS is untouched.
- ERET: pc ← epc; epc unchanged.
- Undefined behaviour: none; every op code is defined.

## Timing
- Reset (async, immediate):
  - pc=RESET_PC, epc=0.
  - RAS empty (ras_empty=1, ras_full=0), both counters 0.
  - npc/pc_plus4 reflect RESET_PC combinationally.
- On each rising edge with rst=0:
  - If npc_op=EXC: the exception update is applied regardless of stall.
  - Else if stall=1: pc, epc, RAS and counters hold; npc still shows the would-be target.
  - Else: pc ← npc, and the RAS/counter/epc side effects of npc_op are applied.
- Latency: npc is valid in the same cycle as its inputs; pc reflects it one edge later.
- Simultaneous RAS events: only one op per cycle, so push and pop never coincide.
- Reset mid-stall or mid-exception: reset wins and all state returns to reset values.

## Structure
- Shared package `scpu_pkg` holds the `npc_op` encoding constants. These replace the old 2-bit NPC defines; codes 000–011 keep their old meaning.
- Sub-module `ras_stack`, parametrised by WIDTH and RAS_DEPTH:
  - circular storage;
  - top pointer;
  - occupancy count;
  - push/pop;
  - top, empty and full outputs.
- `pc_unit` holds the PC and EPC registers, the target mux, alignment check and statistics counters.

## Test plan
- Reset: assert rst asynchronously mid-cycle → pc=0x3000, ras_empty=1, counters 0 before the next edge; release and run PLUS4 three edges → pc=0x300C.
- Branch/jump:
  - pc=0x3000, BRANCH imm[15:0]=0xFFFF → npc=0x3000.
  - JUMP imm=0x0000100 → npc=0x00000400.
  - PLUS4 at pc=0xFFFF_FFFC → pc=0.
- RAS:
  - JAL from 0x3000 then RET with rs=0x3004 → hit_cnt=1, ras_empty=1.
  - RET with empty stack → miss_cnt=1, pc=rs.
  - Five JALs with RAS_DEPTH=4 → ras_full=1; four RETs hit entries 2–5 and the fifth RET misses.
- Stall: stall=1 with JAL for 3 cycles → pc, RAS and counters unchanged; release → single push.
- Exception:
  - At pc=0x3010, EXC while stall=1 → epc=0x3010, pc=0x4180.
  - Then ERET → pc=0x3010.
- Misalignment: RS with rs=0x3006 → addr_err=1, npc=0x3004.
